// File: rtl/step_enable_if.sv
// Control/status bundle between the pacing stage and whatever drives it:
// the raw button, mode/run/divisor controls, and the enable and debounced-level outputs.
interface step_enable_if #(
  parameter int DIV_WIDTH = 8
) ();
  logic                 btn;
  logic                 mode;
  logic                 run;
  logic [DIV_WIDTH-1:0] div;
  logic                 enable;
  logic                 btn_db;

  modport master (
    output btn,
    output mode,
    output run,
    output div,
    input  enable,
    input  btn_db
  );

  modport slave (
    input  btn,
    input  mode,
    input  run,
    input  div,
    output enable,
    output btn_db
  );
endinterface

// File: rtl/step_enable_gen.sv
// Counter pacing stage: manual steps from a debounced, edge-detected push-button,
// or periodic ticks from a reloadable prescaler, selected by mode into a registered enable.
module step_enable_gen #(
  parameter int DIV_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_WIDTH        = 3
) (
  input  logic         clk,
  input  logic         rst,
  step_enable_if.slave bus
);

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1_q,         s1_d;
  logic                 btn_s_q,      btn_s_d;
  logic                 btn_db_q,     btn_db_d;
  logic [DB_WIDTH-1:0]  db_cnt_q,     db_cnt_d;
  logic                 btn_db_dly_q, btn_db_dly_d;
  logic                 active_dly_q, active_dly_d;
  logic [DIV_WIDTH-1:0] presc_q,      presc_d;
  logic                 enable_q,     enable_d;

  logic                 press;
  logic                 active;
  logic                 tick;

  always_comb begin
    s1_d         = bus.btn;
    btn_s_d      = s1_q;

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    btn_db_d     = btn_db_q;
    db_cnt_d     = db_cnt_q;
    if (btn_s_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_s_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_WIDTH'(1);
    end

    btn_db_dly_d = btn_db_q;
    press        = btn_db_q & ~btn_db_dly_q;

    // First active cycle only loads the divisor, so every (re)start gets a full period.
    active       = bus.mode & bus.run;
    active_dly_d = active;
    tick         = 1'b0;
    presc_d      = presc_q;
    if (!active) begin
      presc_d = '0;
    end else if (!active_dly_q) begin
      presc_d = bus.div;
    end else if (presc_q == '0) begin
      tick    = 1'b1;
      presc_d = bus.div;
    end else begin
      presc_d = presc_q - DIV_WIDTH'(1);
    end

    enable_d     = bus.mode ? tick : press;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      db_cnt_q     <= '0;
      btn_db_dly_q <= 1'b0;
      active_dly_q <= 1'b0;
      presc_q      <= '0;
      enable_q     <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      btn_s_q      <= btn_s_d;
      btn_db_q     <= btn_db_d;
      db_cnt_q     <= db_cnt_d;
      btn_db_dly_q <= btn_db_dly_d;
      active_dly_q <= active_dly_d;
      presc_q      <= presc_d;
      enable_q     <= enable_d;
    end
  end

  assign bus.enable = enable_q;
  assign bus.btn_db = btn_db_q;

endmodule

// File: tb/tb_step_enable_gen.sv
// Directed bench for step_enable_gen: reset behaviour, debounce/glitch rejection,
// manual press latency, auto tick spacing, run gating and asynchronous reset mid-period.
module tb_step_enable_gen;

  localparam int DIV_WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   pulses;

  step_enable_if #(.DIV_WIDTH(DIV_WIDTH)) bus ();

  step_enable_gen #(
    .DIV_WIDTH      (DIV_WIDTH),
    .DEBOUNCE_CYCLES(4),
    .DB_WIDTH       (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pulses   = 0;
    rst      = 1'b1;
    bus.btn  = 1'b1;
    bus.mode = 1'b0;
    bus.run  = 1'b0;
    bus.div  = '0;

    // Held button through reset: nothing leaks out while rst is high.
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_enable", bus.enable, 1'b0);
      check("rst_btn_db", bus.btn_db, 1'b0);
    end
    rst = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 15; n++) begin
      step();
      check("t1_enable", bus.enable, (n == 7));
      if (bus.enable) pulses++;
    end
    check("t1_btn_db", bus.btn_db, 1'b1);
    check("t1_pulses", pulses, 1);

    // Release never produces a pulse.
    bus.btn = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("t1_release_enable", bus.enable, 1'b0);
    end
    check("t1_release_btn_db", bus.btn_db, 1'b0);

    // Three-sample glitch is discarded.
    bus.btn = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      if (n == 4) bus.btn = 1'b0;
      step();
      check("t2_glitch_enable", bus.enable, 1'b0);
      check("t2_glitch_btn_db", bus.btn_db, 1'b0);
    end

    // Clean press: single pulse right after edge k+6, downstream count 0 -> 1.
    bus.btn = 1'b1;
    pulses  = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      check("t3_press_enable", bus.enable, (n == 7));
      if (bus.enable) pulses++;
    end
    bus.btn = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("t3_release_enable", bus.enable, 1'b0);
      if (bus.enable) pulses++;
    end
    check("t3_count", pulses, 1);

    // Auto, div=3: pulses every 4 cycles.
    bus.mode = 1'b1;
    bus.run  = 1'b1;
    bus.div  = 8'd3;
    pulses   = 0;
    for (int n = 1; n <= 21; n++) begin
      step();
      check("t4_tick_enable", bus.enable, (n >= 5) && (n % 4 == 1));
      if (bus.enable) pulses++;
    end
    check("t4_count", pulses, 5);

    // Auto, div=0: continuous enable, run gating and one-cycle restart gap.
    bus.run = 1'b0;
    step();
    step();
    check("t5_idle_enable", bus.enable, 1'b0);
    bus.div = 8'd0;
    bus.run = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      check("t5_cont_enable", bus.enable, (n >= 2));
    end
    bus.run = 1'b0;
    step();
    check("t5_rundrop_enable", bus.enable, 1'b0);
    bus.run = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      check("t5_restart_enable", bus.enable, (n >= 2));
    end

    // Auto, div=7, button pressed meanwhile: button ignored for enable but btn_db tracks it.
    bus.run = 1'b0;
    bus.div = 8'd7;
    step();
    step();
    bus.run = 1'b1;
    bus.btn = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      check("t6_tick_enable", bus.enable, (n == 9));
    end
    check("t6_btn_db", bus.btn_db, 1'b1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_enable", bus.enable, 1'b0);
    check("t6_async_btn_db", bus.btn_db, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("t6_restart_enable", bus.enable, (n == 9));
    end
    check("t6_restart_btn_db", bus.btn_db, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/step_enable_gen.md
Name: step_enable_gen

Overview:
Upstream pacing stage for the 4-bit counter. It produces the counter's enable from one of two sources:
- Manual: a raw push-button, which is synchronised, debounced and edge-detected into one-cycle step pulses.
- Auto: a programmable prescaler that emits a periodic one-cycle tick.

The enable output connects directly to the counter's enable input. Both blocks share the same clk and rst.

Parameters:
DIV_WIDTH, 8, width of prescale divisor input and internal down-counter
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a new button level (min 1)
DB_WIDTH, 3, width of debounce counter; must hold DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
btn  input  1  raw asynchronous push-button level (bouncy)
mode  input  1  0 = manual step from btn, 1 = auto tick from prescaler
run  input  1  gates prescaler in auto mode; ignored when mode=0
div  input  DIV_WIDTH  prescale divisor; tick period is div+1 cycles
enable  output  1  registered enable to counter; one-cycle pulses (continuous when div=0 in auto)
btn_db  output  1  debounced button level (status)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. Asserting rst clears all flops immediately, without waiting for a clock edge.
- Reset values: enable=0, btn_db=0. Sync flops, debounce counter, prescaler counter, btn_db_d and active_d are all 0.

Synchroniser:
- Two flops, btn -> s1 -> btn_s.
- btn_s lags btn by 2 edges.

Debounce:
- If btn_s == btn_db: db_cnt <= 0.
- Else if db_cnt == DEBOUNCE_CYCLES-1: btn_db <= btn_s, db_cnt <= 0.
- Else: db_cnt <= db_cnt+1.
- Net effect: any mismatch run shorter than DEBOUNCE_CYCLES samples is discarded.

Edge detect:
- btn_db_d <= btn_db.
- press = btn_db & ~btn_db_d.
- Rising edge only; release never produces a pulse.

Prescaler, with active = mode & run and active_d registered:
- active & ~active_d: presc <= div (load; div is sampled only at load/reload).
- active & active_d & presc==0: tick, presc <= div.
- active & active_d & presc!=0: presc <= presc-1.
- ~active: presc <= 0, no tick.

Output register:
- enable <= mode ? tick : press.

Latency:
- Manual: btn first sampled high at edge k and held stable ⇒ enable high for exactly the one cycle following edge k+DEBOUNCE_CYCLES+2.
- Auto: active first seen at edge e ⇒ enable pulses follow edges e+div+1, e+2(div+1), …
- div=0 ⇒ enable continuously high from after edge e+1.

Mode and run changes:
- mode 1→0: prescaler goes idle; next enable reflects press only.
- mode 0→1: a press coinciding with the switch is dropped; the debouncer keeps tracking, so no stale pulse later.
- btn activity while mode=1 is ignored for enable but still updates btn_db.
- run deassert: enable is low from the next cycle. run reassert restarts the full div+1 period (no partial period is carried over).
- div changed mid-period: takes effect at the next reload.

Reset mid-operation:
- Pending debounce and prescale progress are lost.
- A button held through reset release is re-debounced and produces exactly one pulse.

Test Plan:
1. DEBOUNCE_CYCLES=4, mode=0: rst=1 with btn=1, then release rst with btn held → enable=0 throughout reset; exactly one 1-cycle enable pulse after release; btn_db=1.
2. mode=0: btn toggles high for 3 cycles then low (glitch) → btn_db stays 0, enable never asserts.
3. mode=0: clean press, btn high 20 cycles, first sampled at edge k → enable high only after edge k+6; no pulse on release; downstream count goes 0→1.
4. mode=1, run=1, div=3 for 20 cycles after active → 5 pulses spaced 4 cycles apart; downstream counter reads 5.
5. mode=1, div=0: enable high continuously starting after second edge; drop run → enable 0 next cycle; reassert run → restart with one-cycle gap.
6. mode=1, div=7: assert rst mid-period → enable and btn_db drop to 0 immediately without a clk edge; after release with run=1, first pulse arrives 8 cycles after active is seen.
